// File: rtl/dmem_pkg.sv
// Shared definitions for the load/store data memory: funct3 codes, handshake states
// and the access-size decode used by the lane aligner.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int NLANE = 4;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RESP = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   // Unused funct3 codes decode as word accesses.
   function automatic size_e f3_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

   function automatic logic f3_illegal(input logic [2:0] f3);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for byte/half/word accesses: store byte enables and
// replicated store data, plus shifted and sign/zero-extended load data.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] raw_word,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_al,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   size_e       size;
   logic [1:0]  eff_off;
   logic [31:0] shifted;

   always_comb begin
      size      = f3_size(funct3);
      eff_off   = off;
      byte_en   = 4'b0001 << off;
      wdata_al  = {4{wdata[7:0]}};
      misalign  = 1'b0;
      rdata_ext = 32'd0;
      // Halfword/word offsets are forced to natural alignment; the flag reports the original.
      case (size)
         SZ_B: begin
            eff_off  = off;
            byte_en  = 4'b0001 << off;
            wdata_al = {4{wdata[7:0]}};
         end
         SZ_H: begin
            eff_off  = {off[1], 1'b0};
            byte_en  = 4'b0011 << eff_off;
            wdata_al = {2{wdata[15:0]}};
            misalign = off[0];
         end
         default: begin
            eff_off  = 2'b00;
            byte_en  = 4'b1111;
            wdata_al = wdata;
            misalign = |off;
         end
      endcase
      shifted = raw_word >> {eff_off, 3'b000};
      case (size)
         SZ_B:    rdata_ext = funct3[2] ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    rdata_ext = funct3[2] ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
         default: rdata_ext = shifted;
      endcase
   end

endmodule

// File: rtl/data_mem_ls.sv
// RISC-V data memory with LB/LH/LW/LBU/LHU/SB/SH/SW sizing and a one-entry registered
// response. Define DMEM_FAULT_CHECK_EN to flag misaligned, illegal and out-of-range accesses.
//
// state  | meaning
// S_IDLE | no response held, rsp_valid=0
// S_RESP | response held in output register, rsp_valid=1
module data_mem_ls
   import dmem_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = $clog2(DEPTH);

`ifdef DMEM_FAULT_CHECK_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic [XLEN-1:0] mem [DEPTH];

   state_e          state_q, state_d;
   logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q, rsp_err_d;

   logic [IDX_W-1:0] idx;
   logic             addr_hi;
   logic             accept;
   logic             fault;
   logic [XLEN-1:0]  raw_word;
   logic [3:0]       byte_en;
   logic [XLEN-1:0]  wdata_al;
   logic [XLEN-1:0]  rdata_ext;
   logic             misalign;

   assign idx      = req_addr[IDX_W+1:2];
   assign addr_hi  = |req_addr[ADDR_W-1:IDX_W+2];
   assign raw_word = mem[idx];

   assign rsp_valid = (state_q == S_RESP);
   assign req_ready = !rsp_valid || rsp_ready;
   assign accept    = req_valid && req_ready;
   assign fault     = FAULT_EN && (misalign || f3_illegal(req_funct3) || addr_hi);

   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   dmem_lane_align u_align (
      .funct3    (req_funct3),
      .off       (req_addr[1:0]),
      .wdata     (req_wdata),
      .raw_word  (raw_word),
      .byte_en   (byte_en),
      .wdata_al  (wdata_al),
      .rdata_ext (rdata_ext),
      .misalign  (misalign)
   );

   always_comb begin
      state_d     = state_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (accept) begin
         state_d     = S_RESP;
         rsp_rdata_d = (req_we || fault) ? '0 : rdata_ext;
         rsp_err_d   = fault;
      end else if (rsp_ready) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // The array is deliberately outside reset; only the write is blocked while rst_n is low.
   always_ff @(posedge clk) begin
      if (rst_n && accept && req_we && !fault) begin
         for (int l = 0; l < NLANE; l++) begin
            if (byte_en[l]) mem[idx][8*l +: 8] <= wdata_al[8*l +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_ls.sv
// Directed-vector bench for data_mem_ls; expectations adapt when DMEM_FAULT_CHECK_EN is defined.
module tb_data_mem_ls;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int vectors    = 0;
   int miscompares = 0;

`ifdef DMEM_FAULT_CHECK_EN
   localparam bit FLT = 1'b1;
`else
   localparam bit FLT = 1'b0;
`endif

   always #5 clk = ~clk;

   data_mem_ls dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
   endtask

   // Single access with rsp_ready high; checks the response one cycle after accept.
   task automatic access(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_data, input logic exp_err);
      present(we, f3, addr, wd);
      rsp_ready = 1'b1;
      step();
      req_valid = 1'b0;
      check({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, ".data"}, rsp_rdata, exp_data);
      check({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      step();
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      rsp_ready  = 1'b1;
      step();
      step();
      check("rst.valid", {31'd0, rsp_valid}, 32'd0);
      check("rst.data", rsp_rdata, 32'd0);
      check("rst.err", {31'd0, rsp_err}, 32'd0);
      check("rst.ready", {31'd0, req_ready}, 32'd1);
      rst_n = 1'b1;
      step();

      access("init0", 1'b1, 3'b010, 32'h00, 32'h1234_5678, 32'd0, 1'b0);
      access("init20", 1'b1, 3'b010, 32'h20, 32'h0, 32'd0, 1'b0);
      access("init40", 1'b1, 3'b010, 32'h40, 32'h0, 32'd0, 1'b0);

      access("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
      access("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

      access("sb21", 1'b1, 3'b000, 32'h21, 32'hAAAA_AA7F, 32'd0, 1'b0);
      access("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0000_7F00, 1'b0);
      access("lb21", 1'b0, 3'b000, 32'h21, 32'h0, 32'h0000_007F, 1'b0);
      access("sb21n", 1'b1, 3'b000, 32'h21, 32'h0000_0080, 32'd0, 1'b0);
      access("lb21n", 1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFF_FF80, 1'b0);
      access("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h0000_0080, 1'b0);

      access("sh42", 1'b1, 3'b001, 32'h42, 32'h5555_8001, 32'd0, 1'b0);
      access("lh42", 1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF_8001, 1'b0);
      access("lhu42", 1'b0, 3'b101, 32'h42, 32'h0, 32'h0000_8001, 1'b0);
      access("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h8001_0000, 1'b0);

      // Backpressure: hold a load response while a store waits.
      present(1'b0, 3'b010, 32'h10, 32'h0);
      rsp_ready = 1'b0;
      step();
      present(1'b1, 3'b010, 32'h10, 32'h1111_1111);
      for (int i = 0; i < 3; i++) begin
         check("stall.ready", {31'd0, req_ready}, 32'd0);
         check("stall.valid", {31'd0, rsp_valid}, 32'd1);
         check("stall.data", rsp_rdata, 32'hDEAD_BEEF);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      check("release.ready", {31'd0, req_ready}, 32'd1);
      step();
      check("b2b.sw.valid", {31'd0, rsp_valid}, 32'd1);
      check("b2b.sw.data", rsp_rdata, 32'd0);
      present(1'b0, 3'b000, 32'h10, 32'h0);
      step();
      check("b2b.lb.valid", {31'd0, rsp_valid}, 32'd1);
      check("b2b.lb.data", rsp_rdata, 32'h0000_0011);
      present(1'b0, 3'b010, 32'h10, 32'h0);
      step();
      check("b2b.lw.data", rsp_rdata, 32'h1111_1111);
      req_valid = 1'b0;
      step();
      check("b2b.idle", {31'd0, rsp_valid}, 32'd0);

      // Reset while a response is held and a store is pending.
      present(1'b0, 3'b010, 32'h40, 32'h0);
      rsp_ready = 1'b0;
      step();
      check("prerst.data", rsp_rdata, 32'h8001_0000);
      present(1'b1, 3'b010, 32'h40, 32'hAAAA_AAAA);
      rsp_ready = 1'b1;
      rst_n     = 1'b0;
      step();
      check("midrst.valid", {31'd0, rsp_valid}, 32'd0);
      check("midrst.data", rsp_rdata, 32'd0);
      check("midrst.err", {31'd0, rsp_err}, 32'd0);
      rst_n     = 1'b1;
      req_valid = 1'b0;
      step();
      access("postrst.lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h8001_0000, 1'b0);

      // Misaligned, illegal and out-of-range accesses.
      access("lw02", 1'b0, 3'b010, 32'h02, 32'h0, FLT ? 32'd0 : 32'h1234_5678, FLT);
      access("lh43", 1'b0, 3'b001, 32'h43, 32'h0, FLT ? 32'd0 : 32'hFFFF_8001, FLT);
      access("ld011", 1'b0, 3'b011, 32'h10, 32'h0, FLT ? 32'd0 : 32'h1111_1111, FLT);
      access("sw400", 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 32'd0, FLT);
      access("lw00", 1'b0, 3'b010, 32'h00, 32'h0, FLT ? 32'h1234_5678 : 32'hCAFE_F00D, 1'b0);
      access("sh41", 1'b1, 3'b001, 32'h41, 32'h0000_7777, 32'd0, FLT);
      access("lw40b", 1'b0, 3'b010, 32'h40, 32'h0, FLT ? 32'h8001_0000 : 32'h8001_7777, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
